// File: rtl/liang_pkg.sv
// Core-wide types for the npc pipeline.
// Fetch adds its state encoding and reset vector.
package liang_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } ifToId_t;

  localparam int IF2ID_W = $bits(ifToId_t);

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  localparam pc_t RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic pc_t align_pc(pc_t p);
    return {p[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/utils_pkg.sv
// Shared helpers for the npc core.
// Wrap-flag pointers for power-of-two queues.
package utils;

  typedef struct packed {
    logic       flag;
    logic [0:0] value;
  } ptr_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    ptr_t n;
    n.value = p.value + 1'b1;
    n.flag  = p.flag ^ (&p.value);
    return n;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry IF->ID buffer.
// Registered output, no bypass; flush drops all entries.
module fetch_queue
  import liang_pkg::*;
  import utils::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [IF2ID_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [IF2ID_W-1:0] head,
  output logic               empty,
  output logic               full,
  output logic [1:0]         count
);

  logic [IF2ID_W-1:0] mem [2];
  ptr_t rd_ptr;
  ptr_t wr_ptr;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr.value == wr_ptr.value)
              && (rd_ptr.flag != wr_ptr.flag);
  assign count = full  ? 2'd2 :
                 empty ? 2'd0 : 2'd1;
  assign head  = mem[rd_ptr.value];

  // Entry storage, written at the tail.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr.value] <= push_data;
    end
  end

  // Pointer update; flush empties by catching up to the tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem
// requests, and the IF->ID queue with redirect flush.
module fetch_unit
  import liang_pkg::*;
#(
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [31:0]        imem_resp_inst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if2id_valid,
  input  logic               if2id_ready,
  output logic [IF2ID_W-1:0] if2id
);

  fetch_state_e state;
  fetch_state_e state_n;
  pc_t          pc;
  pc_t          req_pc;

  logic         hs;
  logic         push;
  logic         pop;
  logic         q_empty;
  logic         q_full;
  logic [1:0]   q_count;
  logic         room;
  logic         issue_ok;
  ifToId_t      push_pkt;

  assign push = (state == FS_WAIT) && imem_resp_valid
             && !redirect_valid;
  assign pop  = if2id_valid && if2id_ready;

  // Room for one more in flight once this cycle's
  // push/pop settles; a pop always frees a slot.
  assign room = pop
             || (!q_full && !(push && q_count == 2'd1));

  assign issue_ok = (state == FS_REQ)
                 || (state == FS_WAIT && imem_resp_valid);

  assign imem_req_valid = !reset && !redirect_valid
                       && issue_ok && room;
  assign imem_req_addr  = pc;
  assign hs             = imem_req_valid && imem_req_ready;

  assign if2id_valid = !q_empty && !reset;

  assign push_pkt.pc   = req_pc;
  assign push_pkt.inst = imem_resp_inst;

  fetch_queue u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_pkt),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (if2id),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  // Next state: track whether the in-flight response is kept.
  always_comb begin
    state_n = state;
    unique case (state)
      FS_REQ: begin
        if (hs) state_n = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_resp_valid) begin
          state_n = hs ? FS_WAIT : FS_REQ;
        end else if (redirect_valid) begin
          state_n = FS_DROP;
        end
      end
      FS_DROP: begin
        if (imem_resp_valid) state_n = FS_REQ;
      end
      default: state_n = FS_REQ;
    endcase
  end

  // State, PC and in-flight PC registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FS_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        pc <= align_pc(redirect_pc);
      end else if (hs) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable
// memory model and an in-order scoreboard of fetched PCs.
module tb_fetch_unit;
  import liang_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic         clock = 1'b0;
  logic         reset;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_inst;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         if2id_valid;
  logic         if2id_ready;
  logic [63:0]  if2id;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if2id_valid     (if2id_valid),
    .if2id_ready     (if2id_ready),
    .if2id           (if2id)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb [$];
  int          lat = 1;
  int          mcnt = 0;
  logic        mem_rdy = 1'b1;
  logic [31:0] maddr = '0;
  logic [31:0] exp_addr = RST_PC;
  logic        obs_v, obs_rv, last_hs;
  logic [31:0] last_addr;
  int          hs_cnt = 0;
  int          pop_cnt = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdy,
                      input logic redir, input logic [31:0] rpc,
                      input logic spur);
    @(negedge clock);
    reset          = rst;
    if2id_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = mem_rdy;
    imem_resp_valid = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_inst  = mdata(maddr);
      end
    end
    if (spur) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = 32'hDEAD_BEEF;
    end
    #1;
    obs_v     = if2id_valid;
    obs_rv    = imem_req_valid;
    last_hs   = imem_req_valid && imem_req_ready;
    last_addr = imem_req_addr;
    if (rst) begin
      sb.delete();
      exp_addr = RST_PC;
      chk("rst_req_valid", 64'(obs_rv), 64'd0);
      chk("rst_if2id_valid", 64'(obs_v), 64'd0);
    end
    if (if2id_valid && if2id_ready) begin
      pop_cnt++;
      if (sb.size() == 0)
        chk("pop_unexpected", 64'(if2id_valid), 64'd0);
      else
        chk("pop", if2id, sb.pop_front());
    end
    if (redir) begin
      chk("redir_req_valid", 64'(obs_rv), 64'd0);
      sb.delete();
      exp_addr = {rpc[31:2], 2'b00};
    end
    if (last_hs) begin
      hs_cnt++;
      chk("req_addr", 64'(imem_req_addr), 64'(exp_addr));
      exp_addr += 32'd4;
      sb.push_back({imem_req_addr, mdata(imem_req_addr)});
      maddr = imem_req_addr;
      mcnt  = lat;
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int h0, p0;
    bit found;
    reset = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_inst = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if2id_ready = 1'b0;

    repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);

    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("first_req", 64'({last_hs, last_addr}), 64'({1'b1, RST_PC}));
    chk("lat_c0", 64'(obs_v), 64'd0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("lat_c1", 64'(obs_v), 64'd0);
    chk("b2b_req1", 64'({last_hs, last_addr}), 64'({1'b1, 32'h8000_0004}));
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("lat_c2", 64'(obs_v), 64'd1);
    chk("b2b_req2", 64'({last_hs, last_addr}), 64'({1'b1, 32'h8000_0008}));

    run(4, 1'b1);
    h0 = hs_cnt;
    p0 = pop_cnt;
    run(10, 1'b1);
    chk("tput_req", 64'(hs_cnt - h0), 64'd10);
    chk("tput_pop", 64'(pop_cnt - p0), 64'd10);

    run(6, 1'b0);
    chk("stall_no_req", 64'(obs_rv), 64'd0);
    chk("stall_valid", 64'(obs_v), 64'd1);
    chk("stall_fill", 64'(sb.size()), 64'd2);
    h0 = hs_cnt;
    run(8, 1'b1);
    chk("resume_req", 64'(hs_cnt - h0), 64'd8);

    lat = 3;
    step(1'b0, 1'b1, 1'b1, 32'h8000_0010, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("req_10", 64'({last_hs, last_addr}), 64'({1'b1, 32'h8000_0010}));
    step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("drop_wait1", 64'(obs_rv), 64'd0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("drop_wait2", 64'(obs_rv), 64'd0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("req_100", 64'({last_hs, last_addr}), 64'({1'b1, 32'h8000_0100}));
    chk("redir_flush_v", 64'(obs_v), 64'd0);
    run(12, 1'b1);

    lat = 1;
    run(6, 1'b1);
    chk("pre_coincide_hs", 64'(last_hs), 64'd1);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0203, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("req_200", 64'({last_hs, last_addr}), 64'({1'b1, 32'h8000_0200}));
    chk("coincide_no_push", 64'(obs_v), 64'd0);
    run(4, 1'b1);

    mem_rdy = 1'b0;
    run(5, 1'b1);
    chk("idle_empty", 64'(obs_v), 64'd0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("spur_no_push", 64'(obs_v), 64'd0);
    chk("spur_still_req", 64'(obs_rv), 64'd1);
    mem_rdy = 1'b1;
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("spur_resume", 64'(last_hs), 64'd1);

    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("wrap_req", 64'({last_hs, last_addr}), 64'({1'b1, 32'hFFFF_FFFC}));
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("wrap_next", 64'({last_hs, last_addr}), 64'({1'b1, 32'h0000_0000}));
    run(4, 1'b1);

    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      found = last_hs;
    end
    chk("find_hs", 64'(found), 64'd1);
    repeat (2) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("post_rst_req", 64'({last_hs, last_addr}), 64'({1'b1, RST_PC}));
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("late_resp_ignored", 64'(obs_v), 64'd0);

    mem_rdy = 1'b0;
    run(8, 1'b1);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_valid", 64'(obs_v), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
